ripple_count_monitor: RTL and testbench
=======================================

Name: ripple_count_monitor

Overview:
Downstream consumer of the 4-bit asynchronous up/down ripple counter. Samples the counter's ripple-settling q bus in the system clock domain and accepts only values held stable for STABLE_CYCLES samples. Classifies each accepted change as an up step, down step or illegal jump, and keeps an extended-width running count. Flags wrap-around events and mismatches against the direction select.

Parameters:
WIDTH, 4, width of the monitored counter bus
EXT_WIDTH, 8, width of the extended running count (must be > WIDTH)
STABLE_CYCLES, 2, consecutive identical samples required before a value is accepted (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
cnt_in  input  WIDTH  counter value (q of the ripple counter), asynchronous to clk
dir_in  input  1  direction select driven to the counter (s): 1 = up, 0 = down
clr  input  1  synchronous clear, active-high
ext_count  output  EXT_WIDTH  extended running count
count_valid  output  1  one-cycle pulse per accepted value
wrap_up  output  1  one-cycle pulse on accepted transition max->0
wrap_down  output  1  one-cycle pulse on accepted transition 0->max
step_err  output  1  one-cycle pulse on accepted change that is not +/-1 mod 2^WIDTH
dir_err  output  1  one-cycle pulse on a legal step whose direction disagrees with dir_in
tracking  output  1  high while in TRACK state

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0; smp, run and acc registers 0; state INIT. clr has identical effect. clr and reset both win over any same-cycle accept.
- Sampler, every edge: smp <= cnt_in. run <= (cnt_in==smp) ? min(run+1, STABLE_CYCLES) : 1.
- Accept condition (combinational): run==STABLE_CYCLES and (state==INIT or smp!=acc). All result registers update on the following edge.
- Latency: if cnt_in settles to v before edge k, outputs reflect v after edge k+STABLE_CYCLES. Example: STABLE_CYCLES=2 gives outputs after edge k+2.
- Glitch rule: a value held fewer than STABLE_CYCLES samples is never accepted and produces no pulse.
- INIT -> TRACK on first accept:
  - acc <= smp; ext_count <= {0, smp}; count_valid=1.
  - No step, wrap or err pulses.
  - tracking goes 1.
- TRACK, on accept, d = (smp - acc) mod 2^WIDTH; acc <= smp; count_valid=1:
  - d==1: ext_count+1 (wraps mod 2^EXT_WIDTH). wrap_up=1 if acc==2^WIDTH-1. dir_err=1 if registered dir_in==0.
  - d==2^WIDTH-1: ext_count-1 (wraps). wrap_down=1 if acc==0. dir_err=1 if registered dir_in==1.
  - otherwise: step_err=1. ext_count low WIDTH bits <= smp, high bits unchanged.
- dir_in is registered once. The compare uses the value registered at the same edge as the last smp sample.
- All pulses last exactly one cycle. A stable unchanged value never re-pulses.
- No handshake: outputs are presented unconditionally; consumers sample on count_valid.

Decomposition:
- Shared package ripple_mon_pkg:
  - state enum {INIT, TRACK}
  - step-class enum {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ERR}
  - MAX_VAL constant derived from WIDTH
- Sub-module stable_sampler: smp/run logic, outputs smp and a stable flag. Reusable for other ripple-counter consumers.

Test Plan:
- Reset with cnt_in=4'd5 held 3 cycles, then release -> first accept: ext_count=8'd5, count_valid pulse, no err, tracking=1.
- dir_in=1, cnt_in steps 5->6->...->15->0, each held 3 cycles -> 11 up accepts. wrap_up pulses only on 15->0. ext_count=8'd16.
- dir_in=0 from ext_count=8'd0 (acc=0), cnt_in steps to 15 -> ext_count=8'd255, wrap_down=1, dir_err=0.
- Ripple glitch: acc=7, cnt_in 7->6 for 1 cycle then 8 held -> only 8 accepted. Up step, ext_count+1, no step_err.
- Jump acc=3 -> 9 held -> step_err=1. ext_count low nibble=9, high nibble unchanged. dir_err=0.
- Up step with dir_in=0 -> dir_err=1, ext_count still +1. Assert clr during an accept cycle -> all outputs 0, state INIT, no pulses.

Source files
------------

// File: rtl/ripple_mon_pkg.sv
// Shared types and constants for ripple-counter consumers.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package ripple_mon_pkg;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ERR
    } step_t;

    localparam int unsigned MON_WIDTH = 4;

    // Largest value of a w-bit counter; 1<<32 wraps to 0 so w=32 still yields all ones.
    function automatic int unsigned max_val(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned MAX_VAL = max_val(MON_WIDTH);

endpackage

// File: rtl/stable_sampler.sv
// Samples an asynchronous bus and flags when the sample has been steady for STABLE_CYCLES edges.
// Latency: smp is cnt one edge late; stable rises STABLE_CYCLES-1 edges after the value is first sampled.
// Backpressure: none, samples every edge unconditionally.
module stable_sampler
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = MON_WIDTH,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] smp,
    output logic             stable
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

    logic [WIDTH-1:0] smp_q, smp_d;
    logic [RW-1:0]    run_q, run_d;

    // Next sample and saturating run length of identical consecutive samples.
    always_comb begin
        smp_d = din;
        run_d = RW'(1);
        if (din == smp_q) begin
            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
        end
    end

    // Sample registers; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            smp_q <= '0;
            run_q <= '0;
        end else begin
            smp_q <= smp_d;
            run_q <= run_d;
        end
    end

    assign smp    = smp_q;
    assign stable = (run_q == RUN_MAX);

endmodule

// File: rtl/ripple_count_monitor.sv
// Tracks a ripple counter: accepts settled values, classifies steps, keeps an extended count.
// Latency: results registered one edge after the accept condition (STABLE_CYCLES edges after settling).
// Backpressure: none; outputs are presented every cycle, consumers qualify with count_valid.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = MON_WIDTH,
    parameter int EXT_WIDTH     = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     cnt_in,
    input  logic                 dir_in,
    input  logic                 clr,
    output logic [EXT_WIDTH-1:0] ext_count,
    output logic                 count_valid,
    output logic                 wrap_up,
    output logic                 wrap_down,
    output logic                 step_err,
    output logic                 dir_err,
    output logic                 tracking
);

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] smp;
    logic             stable;

    stable_sampler #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .din    (cnt_in),
        .smp    (smp),
        .stable (stable)
    );

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [EXT_WIDTH-1:0] ext_count_q, ext_count_d;
    logic                 dir_q, dir_d;
    logic                 count_valid_q, count_valid_d;
    logic                 wrap_up_q, wrap_up_d;
    logic                 wrap_down_q, wrap_down_d;
    logic                 step_err_q, step_err_d;
    logic                 dir_err_q, dir_err_d;

    logic             accept;
    logic [WIDTH-1:0] diff;
    step_t            step_cls;

    // Accept a settled value that is either the first one or differs from the last accepted.
    always_comb begin
        accept   = stable && ((state_q == ST_INIT) || (smp != acc_q));
        diff     = smp - acc_q;
        step_cls = STEP_NONE;
        if (state_q == ST_TRACK) begin
            if (diff == WIDTH'(1))       step_cls = STEP_UP;
            else if (diff == TOP_VAL)    step_cls = STEP_DOWN;
            else                         step_cls = STEP_ERR;
        end
    end

    // Next-state, running count and one-cycle event pulses for an accepted value.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        ext_count_d   = ext_count_q;
        dir_d         = dir_in;
        count_valid_d = 1'b0;
        wrap_up_d     = 1'b0;
        wrap_down_d   = 1'b0;
        step_err_d    = 1'b0;
        dir_err_d     = 1'b0;
        if (accept) begin
            state_d       = ST_TRACK;
            acc_d         = smp;
            count_valid_d = 1'b1;
            case (step_cls)
                STEP_UP: begin
                    ext_count_d = ext_count_q + EXT_WIDTH'(1);
                    wrap_up_d   = (acc_q == TOP_VAL);
                    dir_err_d   = !dir_q;
                end
                STEP_DOWN: begin
                    ext_count_d = ext_count_q - EXT_WIDTH'(1);
                    wrap_down_d = (acc_q == '0);
                    dir_err_d   = dir_q;
                end
                STEP_ERR: begin
                    // A jump only resynchronises the low bits; the extension is kept.
                    ext_count_d = {ext_count_q[EXT_WIDTH-1:WIDTH], smp};
                    step_err_d  = 1'b1;
                end
                default: begin
                    ext_count_d = EXT_WIDTH'(smp);
                end
            endcase
        end
    end

    // Result registers; reset and clear both override a same-cycle accept.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q       <= ST_INIT;
            acc_q         <= '0;
            ext_count_q   <= '0;
            dir_q         <= 1'b0;
            count_valid_q <= 1'b0;
            wrap_up_q     <= 1'b0;
            wrap_down_q   <= 1'b0;
            step_err_q    <= 1'b0;
            dir_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            ext_count_q   <= ext_count_d;
            dir_q         <= dir_d;
            count_valid_q <= count_valid_d;
            wrap_up_q     <= wrap_up_d;
            wrap_down_q   <= wrap_down_d;
            step_err_q    <= step_err_d;
            dir_err_q     <= dir_err_d;
        end
    end

    assign ext_count   = ext_count_q;
    assign count_valid = count_valid_q;
    assign wrap_up     = wrap_up_q;
    assign wrap_down   = wrap_down_q;
    assign step_err    = step_err_q;
    assign dir_err     = dir_err_q;
    assign tracking    = (state_q == ST_TRACK);

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: table of held counter values with expected results.
// Latency: expected pulses are tied to the exact cycle they must appear.
// Backpressure: not applicable.
module tb_ripple_count_monitor;

    logic       clk;
    logic       rst_n;
    logic [3:0] cnt_in;
    logic       dir_in;
    logic       clr;
    logic [7:0] ext_count;
    logic       count_valid;
    logic       wrap_up;
    logic       wrap_down;
    logic       step_err;
    logic       dir_err;
    logic       tracking;

    ripple_count_monitor #(
        .WIDTH         (4),
        .EXT_WIDTH     (8),
        .STABLE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_in      (cnt_in),
        .dir_in      (dir_in),
        .clr         (clr),
        .ext_count   (ext_count),
        .count_valid (count_valid),
        .wrap_up     (wrap_up),
        .wrap_down   (wrap_down),
        .step_err    (step_err),
        .dir_err     (dir_err),
        .tracking    (tracking)
    );

    typedef struct {
        logic [3:0] cnt;
        logic       dir;
        int         hold;
        bit         acc;
        logic [7:0] ext;
        logic [3:0] flags;   // {wrap_up, wrap_down, step_err, dir_err}
    } vec_t;

    typedef struct {
        logic [7:0] ext;
        logic [3:0] flags;
        int         cyc;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   split;
    bit   chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic d, input int h,
                                input bit a, input logic [7:0] x, input logic [3:0] f);
        vec_t v;
        v.cnt = c; v.dir = d; v.hold = h; v.acc = a; v.ext = x; v.flags = f;
        return v;
    endfunction

    task automatic run_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i < hi; i++) begin
            cnt_in = tbl[i].cnt;
            dir_in = tbl[i].dir;
            if (tbl[i].acc) begin
                e.ext   = tbl[i].ext;
                e.flags = tbl[i].flags;
                e.cyc   = cyc + tbl[i].hold;
                exp_q.push_back(e);
            end
            tick(tbl[i].hold);
        end
    endtask

    // Scoreboard: every count_valid must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (count_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(count_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ext_count", 32'(ext_count), 32'(mon_e.ext));
                    chk("flags{wu,wd,se,de}", 32'({wrap_up, wrap_down, step_err, dir_err}),
                        32'(mon_e.flags));
                    chk("tracking", 32'(tracking), 32'd1);
                    chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end else begin
                chk("pulse_without_valid", 32'({wrap_up, wrap_down, step_err, dir_err}), 32'd0);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        cnt_in = 4'd5;
        dir_in = 1'b1;

        // Part A: first accept, hold without re-pulse, up run 6..15 then wrap to 0.
        tbl.push_back(mk(4'd5, 1'b1, 3, 1'b1, 8'd5, 4'b0000));
        tbl.push_back(mk(4'd5, 1'b1, 4, 1'b0, 8'd0, 4'b0000));
        for (int v = 6; v <= 15; v++) begin
            tbl.push_back(mk(4'(v), 1'b1, 3, 1'b1, 8'(v), 4'b0000));
        end
        tbl.push_back(mk(4'd0, 1'b1, 3, 1'b1, 8'd16, 4'b1000));
        split = tbl.size();
        // Part B: re-init at 0 after clear, down wrap, jumps, glitch, direction mismatches.
        tbl.push_back(mk(4'd0,  1'b0, 3, 1'b1, 8'd0,   4'b0000));
        tbl.push_back(mk(4'd15, 1'b0, 3, 1'b1, 8'd255, 4'b0100));
        tbl.push_back(mk(4'd14, 1'b0, 3, 1'b1, 8'hFE,  4'b0000));
        tbl.push_back(mk(4'd7,  1'b0, 3, 1'b1, 8'hF7,  4'b0010));
        tbl.push_back(mk(4'd6,  1'b1, 1, 1'b0, 8'h00,  4'b0000));
        tbl.push_back(mk(4'd8,  1'b1, 3, 1'b1, 8'hF8,  4'b0000));
        tbl.push_back(mk(4'd3,  1'b1, 3, 1'b1, 8'hF3,  4'b0010));
        tbl.push_back(mk(4'd9,  1'b1, 3, 1'b1, 8'hF9,  4'b0010));
        tbl.push_back(mk(4'd10, 1'b0, 3, 1'b1, 8'hFA,  4'b0001));
        tbl.push_back(mk(4'd9,  1'b1, 3, 1'b1, 8'hF9,  4'b0001));
        tbl.push_back(mk(4'd9,  1'b1, 3, 1'b0, 8'h00,  4'b0000));

        // Reset held with a steady input: nothing may be accepted.
        tick(3);
        @(negedge clk);
        chk("rst_ext_count", 32'(ext_count), 32'd0);
        chk("rst_count_valid", 32'(count_valid), 32'd0);
        chk("rst_tracking", 32'(tracking), 32'd0);
        chk("rst_pulses", 32'({wrap_up, wrap_down, step_err, dir_err}), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_range(0, split);

        // Clear lands on the edge where 3 would have been accepted.
        cnt_in = 4'd3;
        dir_in = 1'b1;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_ext_count", 32'(ext_count), 32'd0);
        chk("clr_count_valid", 32'(count_valid), 32'd0);
        chk("clr_tracking", 32'(tracking), 32'd0);
        chk("clr_pulses", 32'({wrap_up, wrap_down, step_err, dir_err}), 32'd0);
        @(posedge clk);
        #1;

        run_range(split, tbl.size());

        tick(4);
        chk("pending_expected", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
